trace_led_scanner: RTL
======================

Name: trace_led_scanner

Overview:
Parametrised trace-to-LED display controller for multi-core cpu7 SoC builds. It takes packed per-core trace words and drives a board LED bank with per-bit active-low polarity. The LED bank shows one channel, cycles through the channels, or shows all channels ORed together. Short pulses are stretched so they are visible to the eye. It sits between cpu7_soc trace outputs and top-level board pins.

Parameters:
CHANNELS, 2, number of trace channels (cores); minimum 1
WIDTH, 12, bits per trace word and LED count
CLOCK_FREQ_MHZ, 27, input clock frequency
TICK_CYCLES, CLOCK_FREQ_MHZ*1000, clocks per 1 ms tick (overridable for sim)
DWELL_MS, 500, auto-scan time per channel in ms; minimum 1
STRETCH_MS, 50, minimum visible on-time of a display bit in ms; 0 disables stretch
ACTIVE_LOW_MASK, 12'h0FF, per-LED polarity; 1 = LED lit when pin low

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
trace_in  in  CHANNELS*WIDTH  packed traces, channel k at [k*WIDTH +: WIDTH]
mode  in  2  0=auto-scan, 1=manual, 2=OR-all, 3=freeze
sel  in  IDX_W  manual channel select (IDX_W = max(1,$clog2(CHANNELS)))
led  out  WIDTH  LED pin drive, polarity applied
chan  out  IDX_W  channel currently displayed (0 in OR-all)
tick  out  1  one-cycle 1 ms strobe

Behaviour:
- One clock, synchronous active-high reset. Reset clears all state: the prescaler, dwell counter and stretch counters go to 0, chan=0, the display register goes to 0, led=ACTIVE_LOW_MASK (all LEDs off), tick=0.
- Prescaler counts 0..TICK_CYCLES-1. tick=1 in the cycle it wraps. The first tick comes TICK_CYCLES cycles after reset release.
- Stage 1 registers trace_in every cycle.
- Stage 2 is the display register. Source word is chosen by mode:
  - mode 0 and mode 1: stage1 word of the current channel.
  - mode 2: bitwise OR of all channels.
- led = display register XOR ACTIVE_LOW_MASK, with no extra logic after the register. Latency is 2 cycles from trace_in to led.
- Stretch, per bit i:
  - If the source bit is 1, the counter loads STRETCH_MS.
  - Otherwise, on a tick, the counter decrements when nonzero.
  - Display bit = source bit OR (counter != 0).
  - With STRETCH_MS=0 there are no counters; display equals source.
- Auto-scan (mode 0):
  - The dwell counter increments on each tick.
  - On the tick where it reaches DWELL_MS-1, it wraps to 0 and chan advances, wrapping from CHANNELS-1 to 0.
  - With CHANNELS=1, chan stays 0.
- Manual (mode 1): chan follows sel, registered with 1 cycle delay. sel >= CHANNELS clamps to CHANNELS-1. The dwell counter is held at 0.
- OR-all (mode 2): chan output = 0. The internal channel index is retained for a later return to mode 0.
- Freeze (mode 3): the display register, stretch counters, chan and dwell counter all hold. Prescaler and tick keep running.
- Any change of the effective displayed channel clears all stretch counters in the same cycle the new chan registers. This covers an auto advance, a manual sel change, and a mode change between OR-all and per-channel. The old channel never bleeds into the new one.
- Changing mode into mode 0 resets the dwell counter to 0. Scanning resumes from the current internal channel.
- Simultaneous events:
  - A source bit that is high in the same cycle as a channel-change clear loads STRETCH_MS; the load wins.
  - A tick coinciding with a load: the load wins.
- Reset mid-operation behaves identically to power-up reset.

Decomposition:
- Package trace_led_pkg holds:
  - the mode_t enum (MODE_SCAN, MODE_MANUAL, MODE_OR, MODE_FREEZE);
  - the idx_w(CHANNELS) helper function.
- Sub-module ms_tick_gen(TICK_CYCLES) provides the prescaler and tick output; it is reusable by other board tops.
- Per-bit stretch counters are a generate loop inside this module.

Test Plan:
Sim params: CHANNELS=3, WIDTH=8, TICK_CYCLES=4, DWELL_MS=3, STRETCH_MS=2, ACTIVE_LOW_MASK=8'hF0.
- Reset: hold rst 3 cycles with trace_in random → led=8'hF0, chan=0, tick=0. After release, tick pulses every 4 cycles, first pulse at cycle 4.
- Auto-scan:
  - Setup: mode=0, ch0=8'h01, ch1=8'h02, ch2=8'h04.
  - Required: led=8'hF1 for 3 ticks, then 8'hF2, then 8'hF4, then back to 8'hF1; chan sequence 0,1,2,0.
- Stretch:
  - Setup: mode=1, sel=0; ch0 bit3 high for 1 cycle.
  - Required: led bit3 goes 1 two cycles later and stays 1 until the second tick after the pulse, then returns to 0.
  - Negative check: with STRETCH_MS=0, bit3 is 1 for exactly 1 cycle.
- Channel-change clear:
  - Setup: manual ch0 pulse on bit0, then sel=1 on the next cycle with ch1=8'h00.
  - Required: led=8'hF0 immediately after the chan change; no stretched bit0.
  - Also: sel=3 → chan=2.
- OR-all / freeze:
  - OR-all: mode=2 with ch0=8'h01, ch1=8'h10, ch2=8'h80 → led=8'h61 (display 8'h91 XOR F0), chan=0.
  - Freeze: switch to mode=3, then change all traces to 0 → led stays 8'h61 for 20 cycles; tick continues.
- Reset mid-scan: assert rst while chan=2 with stretch counters active → next cycle led=8'hF0, chan=0. Dwell restarts with a full 3 ticks on ch0.

Source files
------------

// File: rtl/trace_led_pkg.sv
// trace_led_pkg: shared mode encoding and index-width helper for the LED scanner
package trace_led_pkg;
  typedef enum logic [1:0] {MODE_SCAN, MODE_MANUAL, MODE_OR, MODE_FREEZE} mode_t;
  function automatic int idx_w(int channels);
    return channels > 1 ? $clog2(channels) : 1;
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: prescaler producing a registered one-cycle strobe every TICK_CYCLES clocks
module ms_tick_gen #(
  parameter int TICK_CYCLES = 27000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(TICK_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + CW'(1);
      tick <= wrap;
    end
  end
endmodule

// File: rtl/trace_led_scanner.sv
// trace_led_scanner: selects/ORs per-core trace words, stretches pulses and drives a polarity-corrected LED bank
module trace_led_scanner
  import trace_led_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH = 12,
  parameter int CLOCK_FREQ_MHZ = 27,
  parameter int TICK_CYCLES = CLOCK_FREQ_MHZ * 1000,
  parameter int DWELL_MS = 500,
  parameter int STRETCH_MS = 50,
  parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK = 12'h0FF,
  localparam int IDX_W = idx_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] trace_in,
  input  logic [1:0]                mode,
  input  logic [IDX_W-1:0]          sel,
  output logic [WIDTH-1:0]          led,
  output logic [IDX_W-1:0]          chan,
  output logic                      tick
);
  localparam int DW = DWELL_MS > 1 ? $clog2(DWELL_MS) : 1;
  localparam int SW = STRETCH_MS > 0 ? $clog2(STRETCH_MS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);
  mode_t m, mode_q;
  logic [CHANNELS*WIDTH-1:0] s1;
  logic [IDX_W-1:0] cur, cur_n;
  logic [DW-1:0] dwell, dwell_n;
  logic or_q, or_n, frz;
  logic [WIDTH-1:0] src, on;
  assign m = mode_t'(mode);
  assign frz = m == MODE_FREEZE;
  ms_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  // Source uses the next channel so a channel change never shows the old word
  always_comb begin
    cur_n = cur;
    dwell_n = dwell;
    src = '0;
    if (m == MODE_MANUAL) begin
      cur_n = 32'(sel) >= CHANNELS ? LAST : sel;
      dwell_n = '0;
    end else if (m == MODE_SCAN && mode_q != MODE_SCAN) begin
      dwell_n = '0;
    end else if (m == MODE_SCAN && tick) begin
      dwell_n = dwell == DW'(DWELL_MS - 1) ? '0 : dwell + DW'(1);
      cur_n = dwell != DW'(DWELL_MS - 1) ? cur : cur == LAST ? '0 : cur + IDX_W'(1);
    end
    or_n = m == MODE_OR || (frz && or_q);
    for (int k = 0; k < CHANNELS; k++)
      if (or_n || 32'(cur_n) == k) src = src | s1[k*WIDTH +: WIDTH];
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (STRETCH_MS > 0) begin : g_s
      logic [SW-1:0] cnt, cnt_n;
      // Load beats channel-change clear, clear beats tick decrement
      always_comb
        cnt_n = src[i] ? SW'(STRETCH_MS) :
                (or_n != or_q || cur_n != cur) ? '0 :
                (tick && cnt != '0) ? cnt - SW'(1) : cnt;
      always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (!frz) cnt <= cnt_n;
      end
      assign on[i] = cnt_n != '0;
    end else begin : g_n
      assign on[i] = src[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      cur <= '0;
      chan <= '0;
      dwell <= '0;
      or_q <= 1'b0;
      mode_q <= MODE_SCAN;
      led <= ACTIVE_LOW_MASK;
    end else begin
      s1 <= trace_in;
      mode_q <= m;
      if (!frz) begin
        cur <= cur_n;
        chan <= or_n ? '0 : cur_n;
        dwell <= dwell_n;
        or_q <= or_n;
        led <= on ^ ACTIVE_LOW_MASK;
      end
    end
  end
endmodule
